rand_range: RTL and testbench
=============================

# rand_range

Downstream consumer of the 8-bit LCG generator. It turns the free-running `rnd` byte stream into an unbiased value in `[0, range)` on request, using rejection sampling followed by a multi-cycle modulo. It sits between the PRNG and game logic such as spawn position, delay or tile selection, which issues one request per random draw.

## Interface
- `W`, 8: width of the random input, range and result.
- `MAX_TRIES`, 16: rejections allowed before a biased sample is forced.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rnd` in W: PRNG output; a new value every cycle.
- `req` in 1: single-cycle request strobe; sampled only in IDLE.
- `range` in W: exclusive upper bound; latched on an accepted `req`.
- `busy` out 1: high from the cycle after an accepted `req` through the cycle `valid` is high.
- `valid` out 1: one-cycle pulse; `val`, `biased` and `err` are meaningful while it is high.
- `val` out W: result in `[0, range-1]`; held until the next `valid`.
- `biased` out 1: the `MAX_TRIES` cap was hit; result taken without rejection.
- `err` out 1: `range` was 0; `val` = 0.

## Operation
- FSM states:
  - IDLE: on `req`, latch `range` into `rng_q`.
    - If `range` = 0, go to DONE with `err` = 1.
    - Otherwise start the divider with 256 / `rng_q` and go to CALC.
  - CALC: wait for the divider's done pulse. Then set `limit` = 256 − remainder (9-bit; 256 when `range` is a power of two), clear `tries`, go to SAMPLE.
  - SAMPLE: read `rnd` once per cycle.
    - If {0,`rnd`} < `limit`: latch it and start the divider with `rnd` / `rng_q`, go to MOD.
    - Else, if `tries` = MAX_TRIES−1: latch it, set `biased`, go to MOD.
    - Otherwise increment `tries` and stay in SAMPLE.
  - MOD: on divider done, `val` = remainder, go to DONE.
  - DONE: pulse `valid`, return to IDLE.
- `req` is ignored while `busy`; no queueing.
- `range` = 1 is legal: `limit` = 256, `val` = 0.
- `tries` is 5 bits and saturates.
- `biased` and `err` are cleared on each accepted `req`.

## Timing
- Divider: restoring, 9-bit dividend, W-bit divisor, 1 bit per cycle. `done` pulses exactly 9 cycles after `start`.
- `req` seen at edge T → CALC occupies T+1..T+9 → first SAMPLE cycle at T+10.
- Accept on first try → MOD T+11..T+19 → `valid` high during cycle T+20.
- Each rejection adds exactly 1 cycle. Worst case is MAX_TRIES−1 extra cycles, i.e. `valid` at T+35 with the defaults.
- `range` = 0: `valid` and `err` high in cycle T+2, with `busy` high in T+1..T+2.
- Reset values: `busy` = 0, `valid` = 0, `val` = 0, `biased` = 0, `err` = 0, FSM = IDLE, divider idle.
- Reset asserted mid-operation aborts the operation with no `valid`. After release the block accepts `req` on the first edge.
- `req` in the same cycle as `valid`: ignored, because the FSM is still in DONE.

## Structure
- Shared package `rand_pkg`:
  - FSM state enum (IDLE, CALC, SAMPLE, MOD, DONE).
  - Constants `RAND_W` = 8 and `DIV_CYCLES` = 9.
- Sub-module `div_seq`:
  - Ports `clk`, `rst`, `start`, `dividend[8:0]`, `divisor[W-1:0]`, `done`, `rem[W-1:0]`.
  - The quotient is not used.
  - Reused for both CALC and MOD; it is never started while running.
- `rand_range` holds the FSM, `rng_q`, `limit`, `tries` and the output registers.

## Test plan
- `range` = 6, `rnd` forced to 251 at the first SAMPLE → `limit` = 252, accepted, `val` = 5, `valid` at T+20, `biased` = 0.
- `range` = 6, `rnd` = 253 then 13 → one rejection, `val` = 1, `valid` at T+21.
- `range` = 0 → `valid` and `err` at T+2, `val` = 0. `range` = 1 → `val` = 0. `range` = 128 → never rejects.
- `range` = 200, `rnd` held at 255 → 16 tries, then `biased` = 1, `val` = 55, `valid` at T+35.
- Second `req` during busy with `range` = 9 → ignored; result uses the first range. `req` asserted in the `valid` cycle → ignored.
- `rst` pulled low during MOD → all outputs 0 asynchronously, no `valid`. After release, `req` with `range` = 10 and `rnd` = 37 → `val` = 7.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared types and constants for the range-limited random draw block.
// Holds the controller state encoding and divider timing.
package rand_pkg;

    localparam int RAND_W     = 8;
    localparam int DIV_CYCLES = 9;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        SAMPLE,
        MOD,
        DONE
    } state_t;

endpackage

// File: rtl/div_seq.sv
// Restoring divider, one dividend bit per cycle; only the remainder is kept.
// The first bit is consumed on the start edge so done lands DIV_CYCLES later.
module div_seq
    import rand_pkg::*;
#(
    parameter int W = RAND_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W:0]   dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] rem
);

    logic [W:0]   sh;
    logic [W-1:0] r;
    logic [W-1:0] d;
    logic [3:0]   cnt;
    logic         run;

    function automatic logic [W-1:0] step(
        input logic [W-1:0] pr,
        input logic         b,
        input logic [W-1:0] dv
    );
        logic [W:0] t;
        t = {pr, b};
        if (t >= {1'b0, dv}) t = t - {1'b0, dv};
        return t[W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
            cnt <= '0;
            r   <= '0;
            sh  <= '0;
            d   <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= 4'(DIV_CYCLES - 1);
            d   <= divisor;
            r   <= step('0, dividend[W], divisor);
            sh  <= {dividend[W-1:0], 1'b0};
        end else if (run) begin
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                r   <= step(r, sh[W], d);
                sh  <= {sh[W-1:0], 1'b0};
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign done = run && (cnt == '0);
    assign rem  = r;

endmodule

// File: rtl/rand_range.sv
// Unbiased draw in [0, range) from a free-running PRNG byte stream:
// rejection sampling against 256 - (256 mod range), then a sequential modulo.
module rand_range
    import rand_pkg::*;
#(
    parameter int W         = RAND_W,
    parameter int MAX_TRIES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] rnd,
    input  logic         req,
    input  logic [W-1:0] range,
    output logic         busy,
    output logic         valid,
    output logic [W-1:0] val,
    output logic         biased,
    output logic         err
);

    localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};

    state_t       state;
    state_t       next;
    logic [W-1:0] rng_q;
    logic [W:0]   limit;
    logic [4:0]   tries;

    logic         div_start;
    logic         div_done;
    logic [W:0]   div_dividend;
    logic [W-1:0] div_divisor;
    logic [W-1:0] div_rem;

    logic accept;
    logic last_try;

    assign accept   = {1'b0, rnd} < limit;
    assign last_try = tries == 5'(MAX_TRIES - 1);

    div_seq #(.W(W)) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (div_divisor),
        .done    (div_done),
        .rem     (div_rem)
    );

    always_comb begin
        next         = state;
        div_start    = 1'b0;
        div_dividend = FULL;
        div_divisor  = rng_q;
        unique case (state)
            IDLE: begin
                // range 0 spends one CALC cycle with the divider left idle
                if (req) begin
                    next = CALC;
                    if (range != '0) begin
                        div_start   = 1'b1;
                        div_divisor = range;
                    end
                end
            end
            CALC: begin
                if (err) next = DONE;
                else if (div_done) next = SAMPLE;
            end
            SAMPLE: begin
                if (accept || last_try) begin
                    div_start    = 1'b1;
                    div_dividend = {1'b0, rnd};
                    next         = MOD;
                end
            end
            MOD: begin
                if (div_done) next = DONE;
            end
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rng_q  <= '0;
            limit  <= '0;
            tries  <= '0;
            val    <= '0;
            biased <= 1'b0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        rng_q  <= range;
                        err    <= range == '0;
                        biased <= 1'b0;
                    end
                end
                CALC: begin
                    if (err) begin
                        val <= '0;
                    end else if (div_done) begin
                        limit <= FULL - {1'b0, div_rem};
                        tries <= '0;
                    end
                end
                SAMPLE: begin
                    if (!accept) begin
                        if (last_try) biased <= 1'b1;
                        else if (tries != '1) tries <= tries + 5'd1;
                    end
                end
                MOD: begin
                    if (div_done) val <= div_rem;
                end
                default: ;
            endcase
        end
    end

    assign busy  = state != IDLE;
    assign valid = state == DONE;

endmodule

// File: tb/tb_rand_range.sv
// Directed bench for rand_range: expected results queued at request time,
// a negedge monitor pops and compares each valid pulse.
module tb_rand_range;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rnd = 8'd0;
    logic       req = 1'b0;
    logic [7:0] range = 8'd0;
    logic       busy;
    logic       valid;
    logic [7:0] val;
    logic       biased;
    logic       err;

    typedef struct {
        int v;
        int b;
        int e;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   t_req = 0;

    rand_range dut (
        .clk   (clk),
        .rst   (rst),
        .rnd   (rnd),
        .req   (req),
        .range (range),
        .busy  (busy),
        .valid (valid),
        .val   (val),
        .biased(biased),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst && valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                ex = sb.pop_front();
                chk("val", int'(val), ex.v);
                chk("biased", int'(biased), ex.b);
                chk("err", int'(err), ex.e);
                chk("latency", cyc + 1 - t_req, ex.lat);
                chk("busy_at_valid", int'(busy), 1);
            end
        end
    end

    // s0 is presented from the first SAMPLE cycle; s1 from the second when two > 1
    task automatic txn(
        input int rg, input int s0, input int s1, input int nseq,
        input int ev, input int eb, input int ee, input int elat,
        input int ign1, input int ign2, input int ign_rg,
        input int abort_k
    );
        exp_t e;
        @(negedge clk);
        req   = 1'b1;
        range = 8'(rg);
        rnd   = 8'd100;
        t_req = cyc + 1;
        if (abort_k == 0) begin
            e.v = ev; e.b = eb; e.e = ee; e.lat = elat;
            sb.push_back(e);
        end
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            req   = 1'b0;
            range = 8'(rg);
            if (k == ign1 || k == ign2) begin
                req   = 1'b1;
                range = 8'(ign_rg);
            end
            if (k < 10) rnd = 8'd100;
            else if (k >= 11 && nseq > 1) rnd = 8'(s1);
            else rnd = 8'(s0);
            if (k == 1) chk("busy_t1", int'(busy), 1);
            if (k == abort_k) begin
                #1 rst = 1'b0;
                #1;
                chk("rst_busy", int'(busy), 0);
                chk("rst_valid", int'(valid), 0);
                chk("rst_val", int'(val), 0);
                chk("rst_biased", int'(biased), 0);
                chk("rst_err", int'(err), 0);
                return;
            end
            if (k > 2 && !busy) break;
        end
        req = 1'b0;
        chk("txn_end_idle", int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_val", int'(val), 0);
        chk("reset_biased", int'(biased), 0);
        chk("reset_err", int'(err), 0);
        rst = 1'b1;

        // rg, s0, s1, nseq, val, biased, err, lat, ign1, ign2, ign_rg, abort
        txn(6, 251, 0, 1, 5, 0, 0, 20, 0, 0, 0, 0);
        txn(6, 253, 13, 2, 1, 0, 0, 21, 0, 0, 0, 0);
        txn(0, 77, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0);
        txn(1, 200, 0, 1, 0, 0, 0, 20, 0, 0, 0, 0);
        txn(128, 255, 0, 1, 127, 0, 0, 20, 0, 0, 0, 0);
        txn(200, 255, 0, 1, 55, 1, 0, 35, 0, 0, 0, 0);
        txn(255, 255, 254, 2, 254, 0, 0, 21, 0, 0, 0, 0);
        txn(6, 251, 0, 1, 5, 0, 0, 20, 5, 20, 9, 0);
        txn(6, 251, 0, 1, 5, 0, 0, 20, 0, 0, 0, 15);

        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        txn(10, 37, 0, 1, 7, 0, 0, 20, 0, 0, 0, 0);

        repeat (5) @(negedge clk);
        chk("pending_results", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
